// File: rtl/avmm_arbiter_m_pkg.sv
// Shared Avalon-MM arbitration types: FSM state encoding and burst counter width.
package avmm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   // One extra bit so a full MAX_BURST burstcount fits in the counter.
   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/avmm_arbiter_m_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter_m #(
   parameter int N  = 2,
   parameter int OW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] ptr,
   output logic [OW-1:0] grant,
   output logic          any
);

   logic [N-1:0] rot;
   logic [OW:0]  off;
   logic [OW:0]  sum;

   // Rotating a doubled copy puts requester ptr at bit 0, so a plain
   // lowest-set-bit encode gives the distance from ptr to the winner.
   always_comb begin
      rot = N'({req, req} >> ptr);
      off = '0;
      for (int i = N - 1; i >= 0; i--)
         if (rot[i]) off = (OW+1)'(i);
      sum = {1'b0, ptr} + off;
      if (sum >= (OW+1)'(N)) sum = sum - (OW+1)'(N);
      grant = sum[OW-1:0];
      any   = |req;
   end

endmodule

// File: rtl/avmm_arbiter_m.sv
// N-master to 1-slave Avalon-MM arbiter; round-robin grant held for a whole transaction.
module avmm_arbiter_m
   import avmm_pkg::*;
#(
   parameter int N         = 2,
   parameter int AW        = 16,
   parameter int DW        = 32,
   parameter int MAX_BURST = 1,
   localparam int CW       = cnt_w(MAX_BURST),
   localparam int OW       = (N > 1) ? $clog2(N) : 1,
   localparam int BW       = DW / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           m_write,
   input  logic [N-1:0]           m_read,
   input  logic [N-1:0][AW-1:0]   m_address,
   input  logic [N-1:0][CW-1:0]   m_burstcount,
   input  logic [N-1:0][BW-1:0]   m_byteenable,
   input  logic [N-1:0][DW-1:0]   m_writedata,
   output logic [N-1:0]           m_waitrequest,
   output logic [N-1:0]           m_readdatavalid,
   output logic [N-1:0][DW-1:0]   m_readdata,
   output logic [AW-1:0]          s_address,
   output logic [CW-1:0]          s_burstcount,
   output logic [BW-1:0]          s_byteenable,
   output logic [DW-1:0]          s_writedata,
   output logic                   s_write,
   output logic                   s_read,
   input  logic                   s_waitrequest,
   input  logic                   s_readdatavalid,
   input  logic [DW-1:0]          s_readdata,
   output logic [OW-1:0]          owner,
   output logic                   busy
);

   state_t        state, state_nxt;
   logic [N-1:0]  req;
   logic [OW-1:0] ptr, grant;
   logic [CW-1:0] cnt, count, bc_w;
   logic          any, beat, last;

   assign req = m_write | m_read;

   rr_arbiter_m #(.N(N), .OW(OW)) u_rr (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .any   (any)
   );

   assign bc_w = (m_burstcount[grant] == '0) ? CW'(1) : m_burstcount[grant];

   // A beat is an accepted write or a returned read word; stray
   // readdatavalid outside READ never counts.
   always_comb begin
      beat = 1'b0;
      case (state)
         WRITE:   beat = m_write[owner] & ~s_waitrequest;
         READ:    beat = s_readdatavalid;
         default: beat = 1'b0;
      endcase
   end

   assign last = beat && (cnt == count - CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
         count <= CW'(1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && any) begin
            owner <= grant;
            count <= bc_w;
            cnt   <= '0;
         end else if (beat) begin
            cnt <= cnt + CW'(1);
         end
         if (last) ptr <= (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (any) state_nxt = m_write[grant] ? WRITE : READ;
         WRITE, READ: if (last) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Only the command matching the granted transaction type reaches the slave.
   always_comb begin
      s_address       = '0;
      s_burstcount    = '0;
      s_byteenable    = '0;
      s_writedata     = '0;
      s_write         = 1'b0;
      s_read          = 1'b0;
      m_waitrequest   = '1;
      m_readdatavalid = '0;
      m_readdata      = '0;
      if (state != IDLE) begin
         s_address              = m_address[owner];
         s_burstcount           = m_burstcount[owner];
         s_byteenable           = m_byteenable[owner];
         s_writedata            = m_writedata[owner];
         s_write                = (state == WRITE) & m_write[owner];
         s_read                 = (state == READ) & m_read[owner];
         m_waitrequest[owner]   = s_waitrequest;
         m_readdatavalid[owner] = (state == READ) & s_readdatavalid;
         m_readdata[owner]      = s_readdata;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_avmm_arbiter_m.sv
// Randomized bench for avmm_arbiter_m against a transaction-level round-robin model.
module tb_avmm_arbiter_m;

   localparam int N = 3, AW = 16, DW = 32, MB = 4, CW = 3, BW = 4;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]         m_write, m_read, m_waitrequest, m_readdatavalid;
   logic [N-1:0][AW-1:0] m_address;
   logic [N-1:0][CW-1:0] m_burstcount;
   logic [N-1:0][BW-1:0] m_byteenable;
   logic [N-1:0][DW-1:0] m_writedata, m_readdata;
   logic [AW-1:0]        s_address;
   logic [CW-1:0]        s_burstcount;
   logic [BW-1:0]        s_byteenable;
   logic [DW-1:0]        s_writedata, s_readdata;
   logic                 s_write, s_read, s_waitrequest, s_readdatavalid;
   logic [1:0]           owner;
   logic                 busy;

   always #5 clk = ~clk;

   avmm_arbiter_m #(.N(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .m_write(m_write), .m_read(m_read), .m_address(m_address),
      .m_burstcount(m_burstcount), .m_byteenable(m_byteenable),
      .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
      .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
      .s_address(s_address), .s_burstcount(s_burstcount),
      .s_byteenable(s_byteenable), .s_writedata(s_writedata),
      .s_write(s_write), .s_read(s_read), .s_waitrequest(s_waitrequest),
      .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
      .owner(owner), .busy(busy)
   );

   // master agents
   int ma_act[N], ma_wr[N], ma_bc[N], ma_beat[N], ma_cmd[N], ma_rx[N], ma_rem[N];
   logic [AW-1:0] ma_addr[N];
   logic [BW-1:0] ma_be[N];
   logic [DW-1:0] ma_data[N][4];
   // slave agent
   logic [DW-1:0] sl_q[$];
   int sl_gap, gap_lo, gap_hi, stall_pct;
   bit sl_fixed, rst_req;
   // reference model: current owner (-1 = idle), type, beats left, pointer
   int exp_own, exp_wr, exp_left, exp_ptr;
   int grants[$];
   int vectors, miscompares;

   function automatic int eff(input int bc);
      return (bc == 0) ? 1 : bc;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int i, input int wr, input int bc);
      ma_act[i] = 1; ma_wr[i] = wr; ma_bc[i] = bc;
      ma_beat[i] = 0; ma_cmd[i] = 0; ma_rx[i] = 0;
      ma_addr[i] = AW'($urandom); ma_be[i] = BW'($urandom);
      for (int k = 0; k < 4; k++) ma_data[i][k] = $urandom;
   endtask

   function automatic bit all_idle();
      bit r = (exp_own < 0) && (sl_q.size() == 0);
      for (int i = 0; i < N; i++) if (ma_act[i] != 0 || ma_rem[i] != 0) r = 0;
      return r;
   endfunction

   task automatic step(input bit do_chk);
      logic [N-1:0] req, e_wr, e_rdv;
      int o, w;
      bit done, found;
      @(negedge clk);
      rst = rst_req;
      for (int i = 0; i < N; i++) begin
         m_write[i]      = (ma_act[i] != 0) && (ma_wr[i] != 0);
         m_read[i]       = (ma_act[i] != 0) && (ma_wr[i] == 0) && (ma_cmd[i] == 0);
         m_address[i]    = ma_addr[i];
         m_burstcount[i] = CW'(ma_bc[i]);
         m_byteenable[i] = ma_be[i];
         m_writedata[i]  = ma_data[i][(ma_beat[i] < 4) ? ma_beat[i] : 0];
      end
      s_waitrequest   = ($urandom_range(99) < stall_pct);
      s_readdatavalid = (sl_q.size() > 0) && (sl_gap == 0);
      s_readdata      = s_readdatavalid ? sl_q[0] : '0;
      #1;
      o = exp_own;
      e_wr = '1; e_rdv = '0;
      if (o >= 0) begin
         e_wr[o]  = s_waitrequest;
         e_rdv[o] = (exp_wr == 0) && s_readdatavalid;
      end
      if (do_chk) begin
         if (o < 0) begin
            chk("busy_idle", busy, 0);
            chk("s_write_idle", s_write, 0);
            chk("s_read_idle", s_read, 0);
            chk("s_addr_idle", s_address, 0);
            chk("s_bc_idle", s_burstcount, 0);
            chk("s_wdata_idle", s_writedata, 0);
         end else begin
            chk("busy", busy, 1);
            chk("owner", owner, o);
            chk("s_write", s_write, (exp_wr != 0) ? m_write[o] : 1'b0);
            chk("s_read", s_read, (exp_wr != 0) ? 1'b0 : m_read[o]);
            chk("s_addr", s_address, ma_addr[o]);
            chk("s_bc", s_burstcount, ma_bc[o]);
            chk("s_be", s_byteenable, ma_be[o]);
            if (exp_wr != 0 && m_write[o]) chk("s_wdata", s_writedata, ma_data[o][ma_beat[o]]);
         end
         chk("m_waitreq", m_waitrequest, e_wr);
         chk("m_rdv", m_readdatavalid, e_rdv);
         for (int i = 0; i < N; i++)
            chk("m_rdata", m_readdata[i], (i == o) ? s_readdata : '0);
      end
      // reference model advance
      req = m_write | m_read;
      if (rst) begin
         exp_own = -1; exp_ptr = 0;
      end else if (o < 0) begin
         found = 0; w = 0;
         for (int k = 0; k < N; k++)
            if (!found && req[(exp_ptr + k) % N]) begin w = (exp_ptr + k) % N; found = 1; end
         if (found) begin
            exp_own = w; exp_wr = m_write[w] ? 1 : 0; exp_left = eff(ma_bc[w]);
            grants.push_back(w);
         end
      end else if ((exp_wr != 0) ? (m_write[o] && !s_waitrequest) : s_readdatavalid) begin
         exp_left--;
         if (exp_left == 0) begin exp_own = -1; exp_ptr = (o + 1) % N; end
      end
      // slave agent
      if (s_readdatavalid) begin
         void'(sl_q.pop_front());
         sl_gap = $urandom_range(gap_hi, gap_lo);
      end else if (sl_gap > 0) sl_gap--;
      if (s_read && !s_waitrequest)
         for (int k = 0; k < eff(int'(s_burstcount)); k++)
            sl_q.push_back(sl_fixed ? DW'(32'hA0 + k) : DW'($urandom));
      // master agents
      for (int i = 0; i < N; i++) if (ma_act[i] != 0) begin
         done = 0;
         if (ma_wr[i] != 0) begin
            if (!m_waitrequest[i]) begin
               ma_beat[i]++;
               if (ma_beat[i] == eff(ma_bc[i])) done = 1;
            end
         end else begin
            if (ma_cmd[i] == 0 && !m_waitrequest[i]) ma_cmd[i] = 1;
            if (m_readdatavalid[i]) ma_rx[i]++;
            if (ma_cmd[i] != 0 && ma_rx[i] == eff(ma_bc[i])) done = 1;
         end
         if (done) begin
            ma_act[i] = 0;
            if (ma_rem[i] > 0) begin
               ma_rem[i]--;
               start(i, $urandom_range(1), $urandom_range(MB));
            end
         end
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      do begin step(1); n++; end while (!all_idle() && n < budget);
      chk("timeout", all_idle(), 1);
   endtask

   task automatic chk_grants(input string tag, input int exp[$]);
      chk({tag, "_count"}, grants.size(), exp.size());
      for (int k = 0; k < exp.size() && k < grants.size(); k++) chk(tag, grants[k], exp[k]);
   endtask

   initial begin
      int n;
      vectors = 0; miscompares = 0;
      for (int i = 0; i < N; i++) begin ma_act[i] = 0; ma_rem[i] = 0; ma_bc[i] = 1; end
      m_write = '0; m_read = '0; m_address = '0; m_burstcount = '0;
      m_byteenable = '0; m_writedata = '0;
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
      rst = 1'b1; rst_req = 1; stall_pct = 0; gap_lo = 0; gap_hi = 0; sl_gap = 0; sl_fixed = 0;
      exp_own = -1; exp_ptr = 0;

      // reset state
      step(0); step(0); step(1);
      chk("owner_rst", owner, 0);
      rst_req = 0;

      // single write from m1
      start(1, 1, 1); ma_addr[1] = 16'h0010; ma_data[1][0] = 32'hCAFE0001;
      run(50);
      chk_grants("single", '{1});

      // simultaneous writes after reset: 0,1,2
      rst_req = 1; step(1); rst_req = 0; grants.delete();
      stall_pct = 30;
      for (int i = 0; i < N; i++) start(i, 1, 1);
      run(200);
      chk_grants("simul", '{0, 1, 2});

      // 4-beat read on m0 with 2-cycle gaps, m1 write waiting
      grants.delete(); stall_pct = 20; sl_fixed = 1; gap_lo = 2; gap_hi = 2;
      start(0, 0, 4); start(1, 1, 2);
      run(200);
      chk_grants("rdburst", '{0, 1});

      // stalled write burst plus burstcount 0 and a read
      grants.delete(); stall_pct = 50; sl_fixed = 0; gap_lo = 0; gap_hi = 2;
      start(1, 1, 3); start(2, 1, 0); start(0, 0, 2);
      run(300);
      chk_grants("wrburst", '{2, 0, 1});

      // reset in the middle of a 4-beat read
      grants.delete(); stall_pct = 0; sl_fixed = 1; gap_lo = 1; gap_hi = 1;
      start(0, 0, 4);
      n = 0;
      while (ma_rx[0] < 2 && n < 60) begin step(1); n++; end
      chk("midrst_reach", ma_rx[0], 2);
      for (int i = 0; i < N; i++) ma_act[i] = 0;
      rst_req = 1; step(1); rst_req = 0;
      step(1);
      chk("busy_after_rst", busy, 0);
      run(50);
      grants.delete();
      start(2, 1, 1); start(0, 1, 1);
      run(100);
      chk_grants("post_rst", '{0, 2});

      // fairness: everyone requesting continuously, 12 transactions
      rst_req = 1; step(1); rst_req = 0; grants.delete();
      stall_pct = 25; sl_fixed = 0; gap_lo = 0; gap_hi = 1;
      for (int i = 0; i < N; i++) begin
         ma_rem[i] = 3;
         start(i, $urandom_range(1), $urandom_range(MB));
      end
      run(3000);
      chk_grants("fair", '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/avmm_arbiter_m.md
Name: avmm_arbiter_m

Overview:
- N-master to 1-slave Avalon-MM arbiter. It is the inverse of the address-decoding crossbar: several initiators (DMA engines, CPU bridge, PCIe BAR) share one slave port, such as a register file or memory controller.
- Round-robin grant; the grant is held for a whole transaction, including bursts up to MAX_BURST beats.
- Losing masters are stalled with waitrequest until they win.

Parameters:
- N, 2, number of masters; must be ≥2.
- AW, 16, address width; passed through unchanged.
- DW, 32, data width.
- MAX_BURST, 1, maximum burstcount; the counter width is $clog2(MAX_BURST)+1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- m  avmm_if.slave[N]  AW/DW  master-side ports; m[i] connects to initiator i.
- s  avmm_if.master  AW/DW  shared slave port.
- owner  output  $clog2(N)  index of the current owner; valid while busy=1.
- busy  output  1  high while state≠IDLE.

Behaviour:
- States: IDLE, WRITE, READ.
- Request vector: req[i] = m[i].write | m[i].read.
- IDLE, when any req is set:
  - Winner = first i with req[i]=1, scanning from ptr, ptr+1, … wrapping modulo N.
  - Register owner<=winner and count<=m[winner].burstcount. A burstcount of 0 is treated as 1.
  - Register cnt<='0.
  - Next state is WRITE if m[winner].write, else READ. If both write and read are asserted, WRITE wins.
- IDLE, when no req is set: stay in IDLE and hold ptr.
- Slave outputs:
  - s.address, s.burstcount, s.byteenable, s.writedata are muxed from m[owner] whenever state≠IDLE.
  - In IDLE these outputs are '0.
  - s.write/s.read = m[owner].write/read only when state≠IDLE, else 0.
- Latency: a request seen in IDLE reaches the slave on the next cycle (1 cycle arbitration latency). There is no combinational path from m[*] request signals to s.write/s.read in IDLE.
- Owner responses: m[owner].waitrequest=s.waitrequest, m[owner].readdatavalid=s.readdatavalid, m[owner].readdata=s.readdata.
- Every non-owner, and every master while in IDLE, sees waitrequest=1, readdatavalid=0, readdata='0.
- WRITE: on each s.write & ~s.waitrequest, cnt<=cnt+1. The beat where cnt==count-1 is accepted returns to IDLE.
- READ: on each s.readdatavalid, cnt<=cnt+1. The beat where cnt==count-1 arrives returns to IDLE.
- READ command phase: s.read is forwarded until the owner drops it after acceptance. Data beats arriving while s.read is still high are counted normally.
- On return to IDLE: ptr<=owner+1 mod N. The returning master therefore has lowest priority.
- Back-to-back: after returning to IDLE there is at least one IDLE cycle before the next grant, so transactions never overlap on s.
- Stray readdatavalid while in IDLE or WRITE is ignored and not forwarded.
- Reset (including mid-burst):
  - state<=IDLE, ptr<=0, owner<=0, cnt<=0, count<=1.
  - busy=0. All m[i].waitrequest=1, readdatavalid=0. s.write=s.read=0.
  - An in-flight slave response after reset is dropped.
- Width rules:
  - cnt and count are $clog2(MAX_BURST)+1 bits; comparisons use count-1 in that width.
  - owner and ptr are $clog2(N) bits. The wrap is explicit for non-power-of-two N: ptr==N-1 → 0.

Decomposition:
- avmm_pkg: state_t enum (IDLE/WRITE/READ) and a count width function of MAX_BURST. This is shared with the crossbar.
- Sub-module rr_arbiter_m (combinational):
  - Inputs: req[N], ptr.
  - Outputs: grant index, any.
  - Implemented as a double-width rotate/priority encode.
  - Unit-testable on its own.
- The top level holds the FSM, the counters and the muxes.

Test Plan:
- Single write, N=2: m[1] writes addr 0x0010, data 0xCAFE0001 with m[0] idle. s.write rises 1 cycle later with that addr/data; m[1].waitrequest follows s. busy=1, owner=1. Back to IDLE after the accepted beat; ptr=0.
- Simultaneous requests, N=3, after reset: all three masters write at once. Grants occur in order 0,1,2, each separated by one IDLE cycle. Losers see waitrequest=1 throughout and hold their writedata unchanged.
- Read burst, MAX_BURST=4: m[0] reads burstcount=4 while m[1] requests a write. The slave returns 4 beats 0xA0..0xA3 with 2-cycle gaps. All 4 beats go to m[0] only; m[1].readdatavalid stays 0. m[1] is granted after the 4th beat plus one IDLE cycle.
- Write burst with stalls: m[1] writes burstcount=3; the slave holds waitrequest for 2 cycles on beat 2. cnt advances only on accepted beats. Exactly 3 s.write accepts occur, then IDLE.
- Reset mid-burst: rst is asserted during beat 2 of a 4-beat read. The next cycle gives busy=0, all waitrequest=1, s.read=0. A later readdatavalid from the slave is not forwarded. The first grant after reset goes to m[0] if it requests.
- Fairness, N=4, all masters requesting continuously for 12 transactions: each master is granted exactly 3 times, in order 0,1,2,3 repeated.
